// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen -- address sequencer for butterfly_core.
//
// Walks the 7 Kyber NTT/INTT layers of a 256-coefficient polynomial. It issues
// one butterfly per cycle: a read address pair, a zeta ROM index and the
// butterfly mode. The read pair is also passed down a delay line of
// RD_LAT+BF_LAT stages, so the matching write-back addresses come out in step
// with the butterfly results.
//
// Optional feature: define NTT_LAYER_SYNC_EN to stall issue at every layer
// boundary until the delay line is empty. A layer then never reads a
// coefficient before the previous layer has written it back.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   start      pulse: begin a transform (ignored while busy)
//   mode_in    0 = NTT, 1 = INTT; sampled with start (2/3 -> err pulse)
//   hold       stall issue; the layer/butterfly counters freeze
//   busy       transform in progress (RUN or DRAIN)
//   done       one-cycle pulse the cycle after the last wr_en
//   err        one-cycle pulse after a start with an illegal mode_in
//   rd_en      read issue valid (rd_addr_a/rd_addr_b/zeta_idx valid with it)
//   rd_addr_a  upper operand address
//   rd_addr_b  lower operand address
//   zeta_idx   zeta ROM index
//   bf_mode    latched mode; 0 while idle
//   wr_en      write-back valid
//   wr_addr_a  write address for out_1
//   wr_addr_b  write address for out_2
module ntt_addr_gen #(
  parameter int N      = 256,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode_in,
  input  logic       hold,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] zeta_idx,
  output logic [1:0] bf_mode,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);

  localparam int         DL         = RD_LAT + BF_LAT;
  localparam logic [6:0] LAST_BFLY  = 7'(N / 2 - 1);
  localparam logic [2:0] LAST_LAYER = 3'd6;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] z;
  } rd_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] a;
    logic [7:0] b;
  } dl_t;

  // Butterfly addressing for layer l, butterfly bf.
  //   NTT : len = 128 >> l, zeta = (1 << l) + grp
  //   INTT: len = 2 << l,   zeta = (128 >> l) - 1 - grp
  // len is a power of two, so the divide/modulo are a shift and a mask.
  // "sh" is log2(len).
  function automatic rd_t calc_addr(input logic [2:0] l, input logic [6:0] bf,
                                    input logic intt);
    logic [3:0] sh;
    logic [7:0] len;
    logic [7:0] grp;
    logic [7:0] off;
    rd_t        r;
    sh   = intt ? ({1'b0, l} + 4'd1) : (4'd7 - {1'b0, l});
    len  = 8'd1 << sh;
    grp  = {1'b0, bf} >> sh;
    off  = {1'b0, bf} & (len - 8'd1);
    r.a  = (grp << (sh + 4'd1)) | off;
    r.b  = r.a + len;
    r.z  = intt ? 7'((8'd128 >> l) - 8'd1 - grp) : 7'((8'd1 << l) + grp);
    return r;
  endfunction

  state_t     state_reg, state_next;
  logic [2:0] layer_reg, layer_next;
  logic [6:0] bfly_reg, bfly_next;
  logic [1:0] mode_reg, mode_next;
  rd_t        rd_reg, rd_next;
  logic       done_reg, done_next;
  logic       err_reg, err_next;

  logic          issue;
  logic          issue_block;
  logic          last_in_layer;
  logic          last_bfly;
  logic          line_empty;
  logic [DL-1:0] vld_vec;
  dl_t           dl_in;

  assign last_in_layer = (bfly_reg == LAST_BFLY);
  assign last_bfly     = last_in_layer && (layer_reg == LAST_LAYER);
  assign line_empty    = ~|vld_vec;
  assign issue         = (state_reg == RUN) && !hold && !issue_block;

`ifdef NTT_LAYER_SYNC_EN
  // Set when the last butterfly of a layer (not the final layer) issues.
  // Issue stays blocked until that butterfly's write-back has left the
  // delay line.
  logic sync_wait_reg, sync_wait_next;

  always_comb begin
    sync_wait_next = sync_wait_reg;
    if (line_empty || state_reg != RUN) begin
      sync_wait_next = 1'b0;
    end
    if (issue && last_in_layer && !last_bfly) begin
      sync_wait_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_wait_reg <= 1'b0;
    end else begin
      sync_wait_reg <= sync_wait_next;
    end
  end

  assign issue_block = sync_wait_reg && !line_empty;
`else
  assign issue_block = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    layer_next = layer_reg;
    bfly_next  = bfly_reg;
    mode_next  = mode_reg;
    rd_next    = rd_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (!mode_in[1]) begin
            state_next = RUN;
            layer_next = 3'd0;
            bfly_next  = 7'd0;
            mode_next  = mode_in;
            // Preload butterfly 0 so it is on the outputs in the first RUN cycle.
            rd_next    = calc_addr(3'd0, 7'd0, mode_in[0]);
          end else begin
            err_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue) begin
          bfly_next = bfly_reg + 7'd1;
          if (last_in_layer) begin
            layer_next = layer_reg + 3'd1;
          end
          if (last_bfly) begin
            state_next = DRAIN;
          end else begin
            rd_next = calc_addr(layer_next, bfly_next, mode_reg[0]);
          end
        end
      end
      DRAIN: begin
        // Nothing new enters in DRAIN. After the next shift the line is
        // empty when stages 0..DL-2 are empty now. The last write-back is
        // then on wr_en this cycle, so done follows it by one cycle.
        if (~|vld_vec[DL-2:0]) begin
          state_next = IDLE;
          done_next  = 1'b1;
          mode_next  = 2'd0;
          rd_next    = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      layer_reg <= 3'd0;
      bfly_reg  <= 7'd0;
      mode_reg  <= 2'd0;
      rd_reg    <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      layer_reg <= layer_next;
      bfly_reg  <= bfly_next;
      mode_reg  <= mode_next;
      rd_reg    <= rd_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // Write-back delay line. It shifts every cycle, so a stalled issue
  // travels down the line as a bubble.
  assign dl_in = {issue, rd_reg.a, rd_reg.b};

  genvar gi;
  generate
    for (gi = 0; gi < DL; gi++) begin : g_dl
      dl_t stage_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) begin
            stage_reg <= '0;
          end else begin
            stage_reg <= dl_in;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (rst) begin
            stage_reg <= '0;
          end else begin
            stage_reg <= g_dl[gi-1].stage_reg;
          end
        end
      end
      assign vld_vec[gi] = stage_reg.vld;
    end
  endgenerate

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign err       = err_reg;
  assign rd_en     = issue;
  assign rd_addr_a = rd_reg.a;
  assign rd_addr_b = rd_reg.b;
  assign zeta_idx  = rd_reg.z;
  assign bf_mode   = mode_reg;
  assign wr_en     = g_dl[DL-1].stage_reg.vld;
  assign wr_addr_a = g_dl[DL-1].stage_reg.a;
  assign wr_addr_b = g_dl[DL-1].stage_reg.b;

endmodule
